// File: rtl/regfile_port_arbiter.sv
// regfile_port_arbiter: shares the register-file write port between CPU writeback and the debug
//   monitor, and sequences monitor register dumps through read port B.
// Latency: CPU and monitor write paths are combinational (0 cycles); cpu_stall and dump_* are registered.
// Backpressure: a starving monitor request stalls the CPU; dump words hold until dump_ready.
//
// Ports:
//   clk, clrn          clock (rising edge), asynchronous active-high reset
//   cpu_we/wn/d        CPU writeback request (always has priority on the write port)
//   cpu_rnb            CPU read-port-B address
//   cpu_stall          registered request for the CPU to suppress writeback
//   dbg_req/wn/d/ack   monitor write request, held until dbg_ack (same-cycle acknowledge)
//   halted             CPU halted; a dump may only start and continue while high
//   dump_start/ready   dump start pulse and consumer acceptance
//   dump_valid/idx/data/busy  dump word stream and in-progress flag
//   rf_we/wn/d/rnb     register file write port and read address B
//   rf_qb              register file read data B
//
// Optional feature: define REGFILE_DUMP_EN to include the dump sequencer. Without it the dump
// outputs are tied to zero, rf_rnb follows cpu_rnb and the dump inputs are ignored.

module regfile_port_arbiter #(
    parameter int STARVE_LIMIT = 8,
    parameter int CNT_W        = 4
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        cpu_we,
    input  logic [4:0]  cpu_wn,
    input  logic [31:0] cpu_d,
    input  logic [4:0]  cpu_rnb,
    output logic        cpu_stall,
    input  logic        halted,
    input  logic        dbg_req,
    input  logic [4:0]  dbg_wn,
    input  logic [31:0] dbg_d,
    output logic        dbg_ack,
    input  logic        dump_start,
    input  logic        dump_ready,
    output logic        dump_valid,
    output logic [4:0]  dump_idx,
    output logic [31:0] dump_data,
    output logic        dump_busy,
    output logic        rf_we,
    output logic [4:0]  rf_wn,
    output logic [31:0] rf_d,
    output logic [4:0]  rf_rnb,
    input  logic [31:0] rf_qb
);

    localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(STARVE_LIMIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // ------------------------------------------------------------------
    // Write-port arbitration
    // ------------------------------------------------------------------
    logic cpu_own;
    logic dbg_denied;

    // A CPU writeback to r0 is a no-op, so it does not claim the port.
    assign cpu_own    = cpu_we && (cpu_wn != 5'd0);
    assign dbg_denied = dbg_req && cpu_own;

    always_comb begin
        rf_we   = 1'b0;
        rf_wn   = cpu_wn;
        rf_d    = cpu_d;
        dbg_ack = 1'b0;
        if (cpu_own) begin
            rf_we = 1'b1;
        end else if (dbg_req) begin
            // A monitor write to r0 is acknowledged so the requester can
            // move on, but nothing is written.
            dbg_ack = 1'b1;
            rf_we   = (dbg_wn != 5'd0);
            rf_wn   = dbg_wn;
            rf_d    = dbg_d;
        end
    end

    // ------------------------------------------------------------------
    // Starvation counter and CPU stall
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] starve_cnt;

    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            starve_cnt <= '0;
            cpu_stall  <= 1'b0;
        end else begin
            if (dbg_denied) begin
                if (starve_cnt != LIMIT)
                    starve_cnt <= starve_cnt + CNT_ONE;
            end else begin
                starve_cnt <= '0;
            end

            // Stall is sticky: once the monitor has starved long enough the
            // CPU stays stalled until the monitor write actually happens.
            if (dbg_ack)
                cpu_stall <= 1'b0;
            else if (dbg_denied && (starve_cnt == LIMIT_M1))
                cpu_stall <= 1'b1;
        end
    end

`ifdef REGFILE_DUMP_EN
    // ------------------------------------------------------------------
    // Register dump sequencer
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_HOLD = 2'd2
    } dump_state_t;

    dump_state_t state;

    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            state      <= S_IDLE;
            dump_valid <= 1'b0;
            dump_busy  <= 1'b0;
            dump_idx   <= 5'd0;
            dump_data  <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (dump_start && halted) begin
                        state     <= S_READ;
                        dump_idx  <= 5'd0;
                        dump_busy <= 1'b1;
                    end
                end
                S_READ: begin
                    if (!halted) begin
                        state      <= S_IDLE;
                        dump_valid <= 1'b0;
                        dump_busy  <= 1'b0;
                        dump_idx   <= 5'd0;
                    end else begin
                        // r0 is reported as zero regardless of what the
                        // register file returns for address 0.
                        dump_data  <= (dump_idx == 5'd0) ? 32'd0 : rf_qb;
                        dump_valid <= 1'b1;
                        state      <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (!halted) begin
                        state      <= S_IDLE;
                        dump_valid <= 1'b0;
                        dump_busy  <= 1'b0;
                        dump_idx   <= 5'd0;
                    end else if (dump_ready) begin
                        dump_valid <= 1'b0;
                        if (dump_idx == 5'd31) begin
                            state     <= S_IDLE;
                            dump_busy <= 1'b0;
                        end else begin
                            dump_idx <= dump_idx + 5'd1;
                            state    <= S_READ;
                        end
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    dump_valid <= 1'b0;
                    dump_busy  <= 1'b0;
                    dump_idx   <= 5'd0;
                end
            endcase
        end
    end

    // The dump owns read port B for the whole sweep.
    assign rf_rnb = dump_busy ? dump_idx : cpu_rnb;
`else
    logic unused_dump_inputs;

    assign unused_dump_inputs = ^{dump_start, dump_ready, halted, rf_qb};
    assign dump_valid = 1'b0;
    assign dump_busy  = 1'b0;
    assign dump_idx   = 5'd0;
    assign dump_data  = 32'd0;
    assign rf_rnb     = cpu_rnb;
`endif

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// tb_regfile_port_arbiter: scoreboard bench for the register-file port arbiter.
// Contains a behavioural 32x32 register file on the rf_* port (r0 reads as zero).
// Expected register contents and dump words are queued when stimulus is driven.

module tb_regfile_port_arbiter;

    localparam int STARVE_LIMIT = 8;

    typedef struct packed {
        logic [4:0]  idx;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        clrn;
    logic        cpu_we;
    logic [4:0]  cpu_wn;
    logic [31:0] cpu_d;
    logic [4:0]  cpu_rnb;
    logic        cpu_stall;
    logic        halted;
    logic        dbg_req;
    logic [4:0]  dbg_wn;
    logic [31:0] dbg_d;
    logic        dbg_ack;
    logic        dump_start;
    logic        dump_ready;
    logic        dump_valid;
    logic [4:0]  dump_idx;
    logic [31:0] dump_data;
    logic        dump_busy;
    logic        rf_we;
    logic [4:0]  rf_wn;
    logic [31:0] rf_d;
    logic [4:0]  rf_rnb;
    logic [31:0] rf_qb;

    int total;
    int bad;

    exp_t wr_q[$];
    exp_t dump_q[$];

    logic [31:0] mem [32];

    regfile_port_arbiter #(
        .STARVE_LIMIT(STARVE_LIMIT),
        .CNT_W(4)
    ) dut (
        .clk(clk),
        .clrn(clrn),
        .cpu_we(cpu_we),
        .cpu_wn(cpu_wn),
        .cpu_d(cpu_d),
        .cpu_rnb(cpu_rnb),
        .cpu_stall(cpu_stall),
        .halted(halted),
        .dbg_req(dbg_req),
        .dbg_wn(dbg_wn),
        .dbg_d(dbg_d),
        .dbg_ack(dbg_ack),
        .dump_start(dump_start),
        .dump_ready(dump_ready),
        .dump_valid(dump_valid),
        .dump_idx(dump_idx),
        .dump_data(dump_data),
        .dump_busy(dump_busy),
        .rf_we(rf_we),
        .rf_wn(rf_wn),
        .rf_d(rf_d),
        .rf_rnb(rf_rnb),
        .rf_qb(rf_qb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural register file: posedge write, combinational read, r0 = 0.
    always @(posedge clk) begin
        if (rf_we && rf_wn != 5'd0)
            mem[rf_wn] <= rf_d;
    end
    assign rf_qb = (rf_rnb == 5'd0) ? 32'd0 : mem[rf_rnb];

    function automatic logic [31:0] pre_val(input int i);
        return 32'(i) * 32'h1111_1111;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        clrn = 1'b1;
        #3;
        total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%0b want=0", cpu_stall); end
        total++; if (dump_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", dump_valid); end
        total++; if (dump_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", dump_busy); end
        total++; if (dump_idx !== 5'd0) begin bad++; $display("FAIL reset_idx got=%0d want=0", dump_idx); end
        total++; if (dump_data !== 32'd0) begin bad++; $display("FAIL reset_data got=%h want=0", dump_data); end
        total++; if (rf_we !== 1'b0 || dbg_ack !== 1'b0) begin bad++; $display("FAIL reset_wport rf_we=%0b dbg_ack=%0b want=0/0", rf_we, dbg_ack); end
        step;
        step;
        clrn = 1'b0;
        @(negedge clk);
        total++; if (cpu_stall !== 1'b0 || dump_busy !== 1'b0) begin bad++; $display("FAIL post_reset stall=%0b busy=%0b want=0/0", cpu_stall, dump_busy); end
    endtask

    task automatic test_readback;
        exp_t e;
        while (wr_q.size() > 0) begin
            e = wr_q.pop_front();
            step;
            cpu_we  = 1'b0;
            dbg_req = 1'b0;
            cpu_rnb = e.idx;
            @(negedge clk);
            total++; if (rf_qb !== e.data) begin bad++; $display("FAIL readback r%0d got=%h want=%h", e.idx, rf_qb, e.data); end
        end
        cpu_rnb = 5'd0;
    endtask

    task automatic test_dbg_write_idle;
        step;
        cpu_we  = 1'b0;
        dbg_req = 1'b1;
        dbg_wn  = 5'd5;
        dbg_d   = 32'hDEAD_BEEF;
        wr_q.push_back('{idx: 5'd5, data: 32'hDEAD_BEEF});
        @(negedge clk);
        total++; if (dbg_ack !== 1'b1) begin bad++; $display("FAIL idle_ack got=%0b want=1", dbg_ack); end
        total++; if (rf_we !== 1'b1 || rf_wn !== 5'd5 || rf_d !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL idle_wport we=%0b wn=%0d d=%h want=1/5/deadbeef", rf_we, rf_wn, rf_d);
        end
        step;
        dbg_req = 1'b0;
        @(negedge clk);
        total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL idle_stall got=%0b want=0", cpu_stall); end
    endtask

    task automatic test_dbg_r0;
        // CPU writeback to r0 does not take the port from the monitor.
        step;
        cpu_we  = 1'b1;
        cpu_wn  = 5'd0;
        cpu_d   = 32'hAAAA_AAAA;
        dbg_req = 1'b1;
        dbg_wn  = 5'd11;
        dbg_d   = 32'h0B0B_0B0B;
        wr_q.push_back('{idx: 5'd11, data: 32'h0B0B_0B0B});
        @(negedge clk);
        total++; if (dbg_ack !== 1'b1 || rf_we !== 1'b1 || rf_wn !== 5'd11 || rf_d !== 32'h0B0B_0B0B) begin
            bad++; $display("FAIL cpu_r0_yield ack=%0b we=%0b wn=%0d d=%h want=1/1/11/0b0b0b0b", dbg_ack, rf_we, rf_wn, rf_d);
        end
        // Five denials, one idle cycle, five more: the idle cycle must clear the count.
        step;
        cpu_wn  = 5'd3;
        cpu_d   = 32'h3333_0001;
        dbg_wn  = 5'd7;
        dbg_d   = 32'h7777_7777;
        repeat (5) step;
        dbg_req = 1'b0;
        step;
        dbg_req = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            total++; if (dbg_ack !== 1'b0 || cpu_stall !== 1'b0) begin
                bad++; $display("FAIL req_drop_clear k=%0d ack=%0b stall=%0b want=0/0", k, dbg_ack, cpu_stall);
            end
            step;
        end
        // Monitor write to r0 with the CPU idle: acked, not performed, count cleared.
        cpu_we = 1'b0;
        dbg_wn = 5'd0;
        @(negedge clk);
        total++; if (dbg_ack !== 1'b1 || rf_we !== 1'b0) begin bad++; $display("FAIL dbg_r0 ack=%0b we=%0b want=1/0", dbg_ack, rf_we); end
        step;
        cpu_we = 1'b1;
        dbg_wn = 5'd7;
        for (int k = 1; k <= STARVE_LIMIT + 1; k++) begin
            @(negedge clk);
            total++; if (cpu_stall !== (k == STARVE_LIMIT + 1)) begin
                bad++; $display("FAIL ack_clear_stall k=%0d got=%0b want=%0b", k, cpu_stall, (k == STARVE_LIMIT + 1));
            end
            step;
        end
        cpu_we = 1'b0;
        @(negedge clk);
        total++; if (dbg_ack !== 1'b1 || rf_wn !== 5'd7) begin bad++; $display("FAIL r0_release ack=%0b wn=%0d want=1/7", dbg_ack, rf_wn); end
        wr_q.push_back('{idx: 5'd7, data: 32'h7777_7777});
        wr_q.push_back('{idx: 5'd3, data: 32'h3333_0001});
        step;
        dbg_req = 1'b0;
        @(negedge clk);
        total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL r0_release_stall got=%0b want=0", cpu_stall); end
    endtask

    task automatic test_starvation;
        step;
        cpu_we  = 1'b1;
        cpu_wn  = 5'd3;
        cpu_d   = 32'hC000_0001;
        dbg_req = 1'b1;
        dbg_wn  = 5'd9;
        dbg_d   = 32'h1234_5678;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            total++; if (dbg_ack !== 1'b0 || rf_wn !== 5'd3 || rf_d !== 32'hC000_0000 + 32'(k)) begin
                bad++; $display("FAIL starve_cpu_wins k=%0d ack=%0b wn=%0d d=%h", k, dbg_ack, rf_wn, rf_d);
            end
            total++; if (cpu_stall !== (k > STARVE_LIMIT)) begin
                bad++; $display("FAIL starve_stall k=%0d got=%0b want=%0b", k, cpu_stall, (k > STARVE_LIMIT));
            end
            step;
            cpu_d = 32'hC000_0000 + 32'(k + 1);
        end
        cpu_we = 1'b0;
        @(negedge clk);
        total++; if (dbg_ack !== 1'b1 || rf_we !== 1'b1 || rf_wn !== 5'd9 || cpu_stall !== 1'b1) begin
            bad++; $display("FAIL starve_grant ack=%0b we=%0b wn=%0d stall=%0b want=1/1/9/1", dbg_ack, rf_we, rf_wn, cpu_stall);
        end
        wr_q.push_back('{idx: 5'd9, data: 32'h1234_5678});
        wr_q.push_back('{idx: 5'd3, data: 32'hC000_000C});
        step;
        dbg_req = 1'b0;
        @(negedge clk);
        total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL starve_release got=%0b want=0", cpu_stall); end
    endtask

    task automatic test_preload;
        step;
        cpu_we = 1'b0;
        for (int i = 1; i < 32; i++) begin
            dbg_req = 1'b1;
            dbg_wn  = 5'(i);
            dbg_d   = pre_val(i);
            @(negedge clk);
            total++; if (dbg_ack !== 1'b1) begin bad++; $display("FAIL preload_ack r%0d got=%0b want=1", i, dbg_ack); end
            step;
        end
        dbg_req = 1'b0;
    endtask

`ifdef REGFILE_DUMP_EN
    task automatic test_dump_ignored;
        step;
        halted     = 1'b0;
        dump_start = 1'b1;
        step;
        dump_start = 1'b0;
        @(negedge clk);
        total++; if (dump_busy !== 1'b0 || dump_valid !== 1'b0) begin
            bad++; $display("FAIL dump_not_halted busy=%0b valid=%0b want=0/0", dump_busy, dump_valid);
        end
    endtask

    task automatic test_dump_full;
        exp_t e;
        int busy_cycles;
        int words;
        busy_cycles = 0;
        words = 0;
        for (int i = 0; i < 32; i++) dump_q.push_back('{idx: 5'(i), data: pre_val(i)});
        step;
        halted     = 1'b1;
        dump_ready = 1'b1;
        dump_start = 1'b1;
        step;
        dump_start = 1'b0;
        for (int n = 0; n < 80; n++) begin
            @(negedge clk);
            dump_start = 1'b0;
            if (dump_busy) begin
                busy_cycles++;
                if (dump_q.size() > 0) begin
                    total++; if (rf_rnb !== dump_q[0].idx) begin bad++; $display("FAIL dump_rnb got=%0d want=%0d", rf_rnb, dump_q[0].idx); end
                end
            end
            if (dump_valid && dump_ready) begin
                // A start pulse in the middle of a dump must be ignored.
                if (dump_idx == 5'd5) dump_start = 1'b1;
                total++;
                if (dump_q.size() == 0) begin
                    bad++; $display("FAIL dump_extra idx=%0d data=%h", dump_idx, dump_data);
                end else begin
                    e = dump_q.pop_front();
                    words++;
                    if (dump_idx !== e.idx || dump_data !== e.data) begin
                        bad++; $display("FAIL dump_word got=%0d/%h want=%0d/%h", dump_idx, dump_data, e.idx, e.data);
                    end
                end
            end
        end
        total++; if (words !== 32) begin bad++; $display("FAIL dump_count got=%0d want=32", words); end
        total++; if (busy_cycles !== 64) begin bad++; $display("FAIL dump_cycles got=%0d want=64", busy_cycles); end
        total++; if (dump_busy !== 1'b0) begin bad++; $display("FAIL dump_done_busy got=%0b want=0", dump_busy); end
        dump_q.delete();
    endtask

    task automatic test_dump_backpressure_abort;
        exp_t e;
        int held;
        bit done;
        held = 0;
        done = 1'b0;
        for (int i = 0; i < 32; i++) dump_q.push_back('{idx: 5'(i), data: pre_val(i)});
        step;
        halted     = 1'b1;
        dump_ready = 1'b1;
        dump_start = 1'b1;
        step;
        dump_start = 1'b0;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (dump_valid && dump_idx == 5'd7 && held < 5) begin
                if (held > 0) begin
                    total++; if (dump_data !== pre_val(7)) begin bad++; $display("FAIL hold_stable n=%0d data=%h want=%h", held, dump_data, pre_val(7)); end
                end
                held++;
                dump_ready = 1'b0;
            end else if (dump_valid && dump_idx == 5'd12) begin
                halted     = 1'b0;
                dump_ready = 1'b0;
                done       = 1'b1;
            end else begin
                dump_ready = 1'b1;
            end
            if (dump_valid && dump_ready) begin
                total++;
                if (dump_q.size() == 0) begin
                    bad++; $display("FAIL bp_extra idx=%0d", dump_idx);
                end else begin
                    e = dump_q.pop_front();
                    if (dump_idx !== e.idx || dump_data !== e.data) begin
                        bad++; $display("FAIL bp_word got=%0d/%h want=%0d/%h", dump_idx, dump_data, e.idx, e.data);
                    end
                end
            end
        end
        total++; if (held !== 5 || !done) begin bad++; $display("FAIL bp_progress held=%0d reached12=%0b want=5/1", held, done); end
        @(negedge clk);
        total++; if (dump_valid !== 1'b0 || dump_busy !== 1'b0 || dump_idx !== 5'd0) begin
            bad++; $display("FAIL abort valid=%0b busy=%0b idx=%0d want=0/0/0", dump_valid, dump_busy, dump_idx);
        end
        total++; if (dump_q.size() !== 20) begin bad++; $display("FAIL abort_left got=%0d want=20", dump_q.size()); end
        dump_q.delete();
        dump_ready = 1'b0;
    endtask
`else
    task automatic test_no_dump;
        step;
        halted     = 1'b1;
        dump_ready = 1'b1;
        dump_start = 1'b1;
        step;
        dump_start = 1'b0;
        for (int n = 1; n <= 6; n++) begin
            cpu_rnb = 5'(n + 10);
            @(negedge clk);
            total++; if (dump_valid !== 1'b0 || dump_busy !== 1'b0 || dump_idx !== 5'd0 || dump_data !== 32'd0) begin
                bad++; $display("FAIL no_dump_tied valid=%0b busy=%0b idx=%0d data=%h", dump_valid, dump_busy, dump_idx, dump_data);
            end
            total++; if (rf_rnb !== 5'(n + 10) || rf_qb !== pre_val(n + 10)) begin
                bad++; $display("FAIL no_dump_rnb rnb=%0d qb=%h want=%0d/%h", rf_rnb, rf_qb, n + 10, pre_val(n + 10));
            end
            step;
        end
        cpu_rnb = 5'd0;
    endtask
`endif

    task automatic test_reset_mid_run;
        step;
        halted     = 1'b1;
        dump_ready = 1'b1;
        dump_start = 1'b1;
        cpu_we     = 1'b1;
        cpu_wn     = 5'd3;
        cpu_d      = 32'h0000_0333;
        dbg_req    = 1'b1;
        dbg_wn     = 5'd9;
        dbg_d      = 32'h0000_0999;
        step;
        dump_start = 1'b0;
        repeat (10) step;
        @(negedge clk);
        total++; if (cpu_stall !== 1'b1) begin bad++; $display("FAIL midrun_stall got=%0b want=1", cpu_stall); end
`ifdef REGFILE_DUMP_EN
        total++; if (dump_busy !== 1'b1) begin bad++; $display("FAIL midrun_busy got=%0b want=1", dump_busy); end
`endif
        #2;
        clrn = 1'b1;
        #1;
        total++; if (cpu_stall !== 1'b0 || dump_valid !== 1'b0 || dump_busy !== 1'b0 || dump_idx !== 5'd0 || dump_data !== 32'd0) begin
            bad++; $display("FAIL midrun_reset stall=%0b valid=%0b busy=%0b idx=%0d data=%h want all 0",
                            cpu_stall, dump_valid, dump_busy, dump_idx, dump_data);
        end
        cpu_we     = 1'b0;
        dbg_req    = 1'b0;
        dump_ready = 1'b0;
        step;
        step;
        clrn = 1'b0;
        repeat (2) step;
        @(negedge clk);
        total++; if (dump_busy !== 1'b0 || dump_valid !== 1'b0 || cpu_stall !== 1'b0) begin
            bad++; $display("FAIL midrun_idle busy=%0b valid=%0b stall=%0b want=0/0/0", dump_busy, dump_valid, cpu_stall);
        end
        halted = 1'b0;
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        clrn       = 1'b1;
        cpu_we     = 1'b0;
        cpu_wn     = 5'd0;
        cpu_d      = 32'd0;
        cpu_rnb    = 5'd0;
        halted     = 1'b0;
        dbg_req    = 1'b0;
        dbg_wn     = 5'd0;
        dbg_d      = 32'd0;
        dump_start = 1'b0;
        dump_ready = 1'b0;

        test_reset;
        test_dbg_write_idle;
        test_readback;
        test_dbg_r0;
        test_readback;
        test_starvation;
        test_readback;
        test_preload;
`ifdef REGFILE_DUMP_EN
        test_dump_ignored;
        test_dump_full;
        test_dump_backpressure_abort;
`else
        test_no_dump;
`endif
        test_reset_mid_run;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
